halfband_outstage: RTL and testbench
====================================

Name: halfband_outstage

Overview:
- Output stage directly downstream of the halfband filter; consumes its full-precision `o_ce`/`o_result` stream.
- Optionally decimates by 2, keeping one selectable phase.
- Applies an arithmetic shift with convergent (round-half-even) rounding, then saturates to the output width.
- Buffers results in a small FIFO behind a valid/ready handshake, with sticky saturation and overflow flags for the control logic.

Parameters:
- IW, 35: input width; matches the filter's full-precision result width.
- OW, 16: output sample width; requires IW-SHIFT >= OW.
- SHIFT, 11: number of LSBs dropped by rounding; 0 means no rounding, pass through.
- OPT_DECIMATE, 1'b1: 1 keeps every other input sample; 0 keeps all samples.
- OPT_PHASE, 1'b0: when decimating, keep samples whose phase bit equals this value.
- LGFIFO, 2: log2 of FIFO depth (4 entries).

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_ce  input  1  input sample strobe (the filter's o_ce)
- i_sample  input  IW  signed filter result
- i_clr  input  1  clears the sticky flags
- o_valid  input/output: output  1  FIFO head valid
- i_ready  input  1  downstream accepts the head sample this cycle
- o_sample  output  OW  signed, rounded, saturated sample
- o_sat  output  1  sticky: a saturation occurred
- o_overflow  output  1  sticky: a sample was dropped because the FIFO was full
- o_fill  output  LGFIFO+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, `i_clk`; reset `i_reset` is synchronous and active-high.
- Reset values:
  - o_valid=0, o_fill=0, o_sat=0, o_overflow=0, o_sample=0.
  - Phase bit = 0; all pipeline strobes = 0.
  - FIFO read and write pointers = 0.
- Reset mid-operation discards pipeline contents and FIFO contents on the same edge.
- Phase bit:
  - Toggles on every i_ce, whether or not the sample is kept.
  - A sample is kept when (!OPT_DECIMATE) || (phase == OPT_PHASE), evaluated with the phase bit before the toggle.
  - After reset, the first i_ce has phase 0.
- Stage 1, registered on kept i_ce (strobe r_ce):
  - Compute r = (x + 2^(SHIFT-1) - 1 + x[SHIFT]) >>> SHIFT.
  - Use an IW+1-bit signed sum so the addition cannot overflow.
  - The result is IW+1-SHIFT bits wide.
  - When SHIFT=0, r = x.
- Stage 2, registered on r_ce (strobe s_ce):
  - If r > 2^(OW-1)-1, output 2^(OW-1)-1 and set o_sat.
  - If r < -2^(OW-1), output -2^(OW-1) and set o_sat.
  - Otherwise output r truncated to OW bits.
- FIFO write: occurs on s_ce.
  - Latency: i_ce at cycle n gives r_ce at n+1 and s_ce at n+2; the FIFO write happens on the edge ending n+2.
  - o_valid rises at n+3 when the FIFO was empty.
- Handshake:
  - A read occurs when o_valid && i_ready; the read pointer advances.
  - o_sample always shows the FIFO head (registered or read-through; must be stable while o_valid && !i_ready).
  - o_sample is undefined-but-stable when !o_valid.
- Full FIFO (o_fill == 2^LGFIFO):
  - An s_ce with no simultaneous read drops the new sample, sets o_overflow, and leaves the contents unchanged.
  - An s_ce coincident with a read is accepted, and o_fill stays unchanged.
- Empty FIFO: i_ready is ignored, there is no pointer movement, and no write-through bypass (minimum latency stays 3).
- Simultaneous read and write at non-full occupancy: o_fill stays unchanged.
- Pointers wrap modulo 2^LGFIFO; o_fill is the difference of (LGFIFO+1)-bit pointers.
- Sticky flags:
  - i_clr clears o_sat and o_overflow.
  - If a set event occurs in the same cycle as i_clr, the set wins.
  - Reset clears both flags.
- The block places no constraint on i_ce spacing; back-to-back i_ce is legal and fully pipelined.

Test Plan:
- Rounding at SHIFT=11, OPT_DECIMATE=0, inputs 0x400, 0xC00, 0x401, -0x400 (−1024): required outputs 0, 2, 1, 0 (half-even ties; 0x401 rounds up).
- Saturation: input 0x7FFFFFF (>>11 = 65535) gives 0x7FFF with o_sat=1; input −0x8000000 gives 0x8000; after i_clr, o_sat=0. i_clr coincident with a saturating sample leaves o_sat=1.
- Decimation, OPT_DECIMATE=1, OPT_PHASE=0: inputs 1..8 (scaled by 2^11), i_ready=1. Required outputs 1, 3, 5, 7; each o_valid appears 3 cycles after its i_ce. With OPT_PHASE=1: 2, 4, 6, 8.
- Backpressure: i_ready=0 and 6 kept samples. o_fill goes to 4; o_overflow sets on the 5th sample; the 5th and 6th samples are lost. Then i_ready=1 drains the first 4 samples in order, one per cycle.
- Full with simultaneous read: FIFO full, s_ce coincident with i_ready=1. The sample is accepted, o_fill stays 4, and o_overflow stays 0.
- Reset mid-stream: assert i_reset with 2 samples in the pipeline and 3 in the FIFO. Next cycle o_valid=0 and o_fill=0; the first post-reset i_ce is phase 0.

Source files
------------

// File: rtl/halfband_outstage_if.sv
// halfband_outstage_if: filter sample stream in, rounded/saturated stream out with valid/ready
interface halfband_outstage_if #(
  parameter int IW = 35,
  parameter int OW = 16
) ();
  logic                 i_ce;
  logic signed [IW-1:0] i_sample;
  logic                 i_ready;
  logic                 o_valid;
  logic signed [OW-1:0] o_sample;
  modport slave (input i_ce, i_sample, i_ready, output o_valid, o_sample);
  modport master (output i_ce, i_sample, i_ready, input o_valid, o_sample);
endinterface

// File: rtl/halfband_outstage.sv
// halfband_outstage: optional 2:1 decimation, round-half-even shift, saturation and a small output FIFO
module halfband_outstage #(
  parameter int IW           = 35,
  parameter int OW           = 16,
  parameter int SHIFT        = 11,
  parameter bit OPT_DECIMATE = 1'b1,
  parameter bit OPT_PHASE    = 1'b0,
  parameter int LGFIFO       = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  halfband_outstage_if.slave bus,
  output logic              o_sat,
  output logic              o_overflow,
  output logic [LGFIFO:0]   o_fill
);
  localparam int RW    = IW + 1 - SHIFT;
  localparam int AW    = IW + 1;
  localparam int PW    = LGFIFO + 1;
  localparam int DEPTH = 1 << LGFIFO;
  logic                 phase_q, r_ce_q, s_ce_q, sat_q, ovf_q;
  logic signed [RW-1:0] r_q, r_d;
  logic signed [OW-1:0] s_q, s_d;
  logic signed [OW-1:0] mem_q [DEPTH];
  logic [LGFIFO:0]      wr_q, rd_q;
  logic                 keep, pos, neg, sat_ev, ovf_ev, rd, wr, full;
  assign keep = bus.i_ce && (!OPT_DECIMATE || phase_q == OPT_PHASE);
  if (SHIFT == 0) begin : g_pass
    assign r_d = RW'(bus.i_sample);
  end else begin : g_rnd
    logic [AW-1:0] sum;
    // Adding half-minus-one plus the kept LSB turns a plain floor shift into round-half-even
    assign sum = {bus.i_sample[IW-1], bus.i_sample} + AW'((1 << (SHIFT - 1)) - 1) + AW'(bus.i_sample[SHIFT]);
    assign r_d = RW'(sum >> SHIFT);
  end
  assign pos    = !r_q[RW-1] && (|r_q[RW-2:OW-1]);
  assign neg    = r_q[RW-1] && !(&r_q[RW-2:OW-1]);
  assign s_d    = pos ? {1'b0, {(OW-1){1'b1}}} : neg ? {1'b1, {(OW-1){1'b0}}} : r_q[OW-1:0];
  assign sat_ev = r_ce_q && (pos || neg);
  assign o_fill = wr_q - rd_q;
  assign full   = o_fill[LGFIFO];
  assign bus.o_valid  = |o_fill;
  assign bus.o_sample = bus.o_valid ? mem_q[rd_q[LGFIFO-1:0]] : '0;
  assign rd     = bus.o_valid && bus.i_ready;
  assign wr     = s_ce_q && (!full || rd);
  assign ovf_ev = s_ce_q && full && !rd;
  assign o_sat      = sat_q;
  assign o_overflow = ovf_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= 1'b0;
      r_ce_q  <= 1'b0;
      s_ce_q  <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      if (bus.i_ce) phase_q <= !phase_q;
      r_ce_q <= keep;
      s_ce_q <= r_ce_q;
      sat_q  <= sat_ev || (sat_q && !i_clr);
      ovf_q  <= ovf_ev || (ovf_q && !i_clr);
      if (wr) wr_q <= wr_q + PW'(1);
      if (rd) rd_q <= rd_q + PW'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (keep) r_q <= r_d;
    if (r_ce_q) s_q <= s_d;
    if (wr) mem_q[wr_q[LGFIFO-1:0]] <= s_q;
  end
endmodule

// File: tb/tb_halfband_outstage.sv
// tb_halfband_outstage: directed vectors into two DUTs (keep phase 0 / phase 1) with queue scoreboards
module tb_halfband_outstage;
  logic clk = 1'b0;
  logic rst, ce, rdy, clr;
  logic signed [34:0] smp;
  logic sat_a, ovf_a, sat_b, ovf_b;
  logic [2:0] fill_a, fill_b;
  logic signed [15:0] qa[$], qb[$];
  bit ph;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  halfband_outstage_if #(.IW(35), .OW(16)) ia ();
  halfband_outstage_if #(.IW(35), .OW(16)) ib ();
  assign ia.i_ce = ce;
  assign ib.i_ce = ce;
  assign ia.i_sample = smp;
  assign ib.i_sample = smp;
  assign ia.i_ready = rdy;
  assign ib.i_ready = rdy;
  halfband_outstage ua (.i_clk(clk), .i_reset(rst), .i_clr(clr), .bus(ia),
                        .o_sat(sat_a), .o_overflow(ovf_a), .o_fill(fill_a));
  halfband_outstage #(.OPT_PHASE(1'b1)) ub (.i_clk(clk), .i_reset(rst), .i_clr(clr), .bus(ib),
                        .o_sat(sat_b), .o_overflow(ovf_b), .o_fill(fill_b));
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  task automatic send(input logic signed [34:0] x, input logic signed [15:0] e, input bit keep);
    @(posedge clk);
    #1;
    ce = 1'b1;
    smp = x;
    if (keep) begin
      if (ph) qb.push_back(e);
      else qa.push_back(e);
    end
    ph = !ph;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ce = 1'b0;
      clr = 1'b0;
    end
  endtask
  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && ia.o_valid && rdy) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_extra: output %0d with nothing expected", ia.o_sample);
      end else chk("a_sample", ia.o_sample, qa.pop_front());
    end
    if (!rst && ib.o_valid && rdy) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_extra: output %0d with nothing expected", ib.o_sample);
      end else chk("b_sample", ib.o_sample, qb.pop_front());
    end
  end
  initial begin
    rst = 1'b1; ce = 1'b0; smp = '0; rdy = 1'b1; clr = 1'b0; ph = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", ia.o_valid, 0);
    chk("rst_fill", fill_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_sample", ia.o_sample, 0);
    // rounding: A keeps even-indexed sends, B gets the zero fillers
    send(35'sh400, 16'sd0, 1); send(35'sd0, 16'sd0, 1);
    send(35'shC00, 16'sd2, 1); send(35'sd0, 16'sd0, 1);
    send(35'sh401, 16'sd1, 1); send(35'sd0, 16'sd0, 1);
    send(-35'sh400, 16'sd0, 1); send(35'sd0, 16'sd0, 1);
    idle(6);
    chk("round_no_sat", sat_a, 0);
    send(35'sh7FFFFFF, 16'sh7FFF, 1); send(35'sd0, 16'sd0, 1);
    idle(6);
    chk("sat_pos", sat_a, 1);
    pulse_clr();
    chk("sat_clr_pos", sat_a, 0);
    send(-35'sh8000000, 16'sh8000, 1); send(35'sd0, 16'sd0, 1);
    idle(6);
    chk("sat_neg", sat_a, 1);
    pulse_clr();
    chk("sat_clr_neg", sat_a, 0);
    send(35'sh7FFFFFF, 16'sh7FFF, 1); send(35'sd0, 16'sd0, 1);
    clr = 1'b1;
    idle(6);
    chk("sat_set_beats_clr", sat_a, 1);
    pulse_clr();
    // decimation and 3-cycle latency
    send(35'sd2048, 16'sd1, 1);
    @(posedge clk); #1 ce = 1'b0;
    @(posedge clk); #1;
    chk("lat_before", ia.o_valid, 0);
    @(posedge clk); #1;
    chk("lat_at3", ia.o_valid, 1);
    for (int k = 2; k <= 8; k++) send(35'(k * 2048), 16'(k), 1);
    idle(8);
    // backpressure with overflow
    rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(35'((10 + k) * 2048), 16'(10 + k), 1);
      send(35'((20 + k) * 2048), 16'(20 + k), 1);
    end
    idle(5);
    chk("bp_fill_a", fill_a, 4);
    chk("bp_fill_b", fill_b, 4);
    chk("bp_no_ovf", ovf_a, 0);
    for (int k = 5; k <= 6; k++) begin
      send(35'((10 + k) * 2048), 16'(10 + k), 0);
      send(35'((20 + k) * 2048), 16'(20 + k), 0);
    end
    idle(5);
    chk("bp_ovf", ovf_a, 1);
    chk("bp_fill_kept", fill_a, 4);
    @(posedge clk); #1 rdy = 1'b1;
    @(posedge clk); #1;
    chk("drain_one", fill_a, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_all", fill_a, 0);
    pulse_clr();
    chk("ovf_clr", ovf_a, 0);
    // full FIFO with a read on the same edge as the write
    rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(35'((30 + k) * 2048), 16'(30 + k), 1);
      send(35'((40 + k) * 2048), 16'(40 + k), 1);
    end
    idle(5);
    chk("full_fill", fill_a, 4);
    send(35'(35 * 2048), 16'sd35, 1);
    send(35'(45 * 2048), 16'sd45, 1);
    @(posedge clk); #1 ce = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("full_rw_fill", fill_a, 4);
    chk("full_rw_no_ovf", ovf_a, 0);
    idle(10);
    // reset mid-stream
    rdy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      send(35'((50 + k) * 2048), 16'(50 + k), 1);
      send(35'((60 + k) * 2048), 16'(60 + k), 1);
    end
    idle(5);
    chk("pre_rst_fill", fill_a, 3);
    send(35'(54 * 2048), 16'sd54, 1);
    send(35'(64 * 2048), 16'sd64, 1);
    send(35'(55 * 2048), 16'sd55, 1);
    @(posedge clk); #1 ce = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    qa.delete();
    qb.delete();
    ph = 1'b0;
    chk("mid_rst_valid", ia.o_valid, 0);
    chk("mid_rst_fill_a", fill_a, 0);
    chk("mid_rst_fill_b", fill_b, 0);
    rdy = 1'b1;
    idle(5);
    send(35'(77 * 2048), 16'sd77, 1);
    send(35'(88 * 2048), 16'sd88, 1);
    idle(8);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
